alu_bit_slice: RTL and testbench

- Registered 1-bit ALU slice, the building block replicated per bit to form the 24-bit single-cycle CPU ALU.
- Computes AND, OR, ADD (full adder with carry in/out) and SLT pass-through of the Less input.
- Per-operand inversion supports SUB (b_invert=1, cin=1) and NOR (both inverted, AND op).
- Results are captured one clock after a valid input; the MSB slice additionally produces set and overflow flags.

---
 rtl/alu_bit_slice_if.sv | 28 ++
 rtl/alu_bit_slice.sv | 52 +++++
 tb/tb_alu_bit_slice.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_bit_slice_if.sv
// alu_bit_slice_if: operand/control inputs and registered results of one ALU bit slice
// Signals:
//   in_valid, a, b, less, cin, a_invert, b_invert, operation[1:0]  -> into the slice
//   result, cout, set, overflow, out_valid                          <- from the slice
//   gen, prop (only with ALU_BIT_GP_EN defined)                     <- from the slice
// Modports: master drives operands and samples results, slave is the slice itself.
interface alu_bit_slice_if;
    logic       in_valid, a, b, less, cin, a_invert, b_invert;
    logic [1:0] operation;
    logic       result, cout, set, overflow, out_valid;
`ifdef ALU_BIT_GP_EN
    logic       gen, prop;
`endif
    modport master (
        output in_valid, a, b, less, cin, a_invert, b_invert, operation,
`ifdef ALU_BIT_GP_EN
        input  gen, prop,
`endif
        input  result, cout, set, overflow, out_valid
    );
    modport slave (
        input  in_valid, a, b, less, cin, a_invert, b_invert, operation,
`ifdef ALU_BIT_GP_EN
        output gen, prop,
`endif
        output result, cout, set, overflow, out_valid
    );
endinterface

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: registered 1-bit ALU slice (AND/OR/ADD/LESS with per-operand inversion)
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset, clears every registered output
//   bus   alu_bit_slice_if.slave (operands/controls in, registered results out)
// Parameter MSB_SLICE: 1 drives set (sum) and overflow (cin ^ carry), 0 ties both to 0.
// Optional macro ALU_BIT_GP_EN: adds registered gen (ax&bx) and prop (ax|bx) outputs.
// Latency is one cycle; with in_valid low the data outputs hold and out_valid drops.
module alu_bit_slice #(
    parameter bit MSB_SLICE = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    alu_bit_slice_if.slave bus
);
    logic ax, bx, s, c, result_next;
    always_comb begin
        ax          = bus.a ^ bus.a_invert;
        bx          = bus.b ^ bus.b_invert;
        s           = ax ^ bx ^ bus.cin;
        c           = (ax & bx) | (ax & bus.cin) | (bx & bus.cin);
        result_next = bus.operation == 2'b00 ? ax & bx :
                      bus.operation == 2'b01 ? ax | bx :
                      bus.operation == 2'b10 ? s : bus.less;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result    <= 1'b0;
            bus.cout      <= 1'b0;
            bus.set       <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
`ifdef ALU_BIT_GP_EN
            bus.gen       <= 1'b0;
            bus.prop      <= 1'b0;
`endif
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.result   <= result_next;
                // carry is captured for every operation so SUB/SLT chains see it
                bus.cout     <= c;
                bus.set      <= MSB_SLICE ? s : 1'b0;
                bus.overflow <= MSB_SLICE ? bus.cin ^ c : 1'b0;
`ifdef ALU_BIT_GP_EN
                bus.gen      <= ax & bx;
                bus.prop     <= ax | bx;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_bit_slice.sv
// tb_alu_bit_slice: vector table, random model comparison, reset and hold sequences
module tb_alu_bit_slice;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_bit_slice_if bus0 ();
    alu_bit_slice_if bus1 ();
    alu_bit_slice #(.MSB_SLICE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    alu_bit_slice #(.MSB_SLICE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // exp = {result, cout, set, overflow} as seen by the MSB instance
    typedef struct {
        logic       a, b, less, cin, ai, bi;
        logic [1:0] op;
        logic [3:0] exp;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(input logic a, b, less, cin, ai, bi, input logic [1:0] op, input logic [3:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.less = less; v.cin = cin; v.ai = ai; v.bi = bi; v.op = op; v.exp = exp;
        return v;
    endfunction

    // reference: {result, cout, set, overflow, gen, prop} of an MSB slice, from arithmetic
    function automatic logic [5:0] model(input vec_t v);
        int ax, bx, total, sum, carry, res;
        ax    = v.ai ? 1 - int'(v.a) : int'(v.a);
        bx    = v.bi ? 1 - int'(v.b) : int'(v.b);
        total = ax + bx + int'(v.cin);
        sum   = total % 2;
        carry = total / 2;
        case (v.op)
            2'd0:    res = (ax == 1 && bx == 1) ? 1 : 0;
            2'd1:    res = (ax == 1 || bx == 1) ? 1 : 0;
            2'd2:    res = sum;
            default: res = int'(v.less);
        endcase
        return {res[0], carry[0], sum[0], (int'(v.cin) != carry) ? 1'b1 : 1'b0,
                (ax == 1 && bx == 1) ? 1'b1 : 1'b0, (ax == 1 || bx == 1) ? 1'b1 : 1'b0};
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e, input logic ev, input logic [1:0] egp);
        chk({tag, " msb result"},    bus1.result,    e[3]);
        chk({tag, " msb cout"},      bus1.cout,      e[2]);
        chk({tag, " msb set"},       bus1.set,       e[1]);
        chk({tag, " msb overflow"},  bus1.overflow,  e[0]);
        chk({tag, " msb out_valid"}, bus1.out_valid, ev);
        chk({tag, " lsb result"},    bus0.result,    e[3]);
        chk({tag, " lsb cout"},      bus0.cout,      e[2]);
        chk({tag, " lsb set"},       bus0.set,       1'b0);
        chk({tag, " lsb overflow"},  bus0.overflow,  1'b0);
        chk({tag, " lsb out_valid"}, bus0.out_valid, ev);
`ifdef ALU_BIT_GP_EN
        chk({tag, " gen"},  bus1.gen,  egp[1]);
        chk({tag, " prop"}, bus1.prop, egp[0]);
        chk({tag, " lsb gen"},  bus0.gen,  egp[1]);
        chk({tag, " lsb prop"}, bus0.prop, egp[0]);
`endif
    endtask

    task automatic drive(input vec_t v, input logic iv);
        bus0.in_valid = iv; bus0.a = v.a; bus0.b = v.b; bus0.less = v.less; bus0.cin = v.cin;
        bus0.a_invert = v.ai; bus0.b_invert = v.bi; bus0.operation = v.op;
        bus1.in_valid = iv; bus1.a = v.a; bus1.b = v.b; bus1.less = v.less; bus1.cin = v.cin;
        bus1.a_invert = v.ai; bus1.b_invert = v.bi; bus1.operation = v.op;
    endtask

    initial begin
        logic [3:0] e;
        logic [1:0] egp;
        logic [5:0] m;
        logic       ev;
        vec_t       r;
        vt[0]  = mk(0,0,0,0,0,0,2'b00,4'b0000);
        vt[1]  = mk(0,1,0,0,0,0,2'b00,4'b0010);
        vt[2]  = mk(1,0,0,0,0,0,2'b00,4'b0010);
        vt[3]  = mk(1,1,0,0,0,0,2'b00,4'b1101);
        vt[4]  = mk(0,0,0,0,0,0,2'b01,4'b0000);
        vt[5]  = mk(0,1,0,0,0,0,2'b01,4'b1010);
        vt[6]  = mk(1,0,0,0,0,0,2'b01,4'b1010);
        vt[7]  = mk(1,1,0,0,0,0,2'b01,4'b1101);
        vt[8]  = mk(1,1,0,0,0,0,2'b10,4'b0101);
        vt[9]  = mk(1,1,0,1,0,0,2'b10,4'b1110);
        vt[10] = mk(0,0,0,1,0,0,2'b10,4'b1011);
        vt[11] = mk(0,0,0,0,1,1,2'b00,4'b1101);
        vt[12] = mk(0,1,0,0,1,1,2'b00,4'b0010);
        vt[13] = mk(1,0,0,0,1,1,2'b00,4'b0010);
        vt[14] = mk(1,1,0,0,1,1,2'b00,4'b0000);
        vt[15] = mk(1,1,0,1,0,1,2'b10,4'b0100);
        vt[16] = mk(0,1,0,1,0,1,2'b11,4'b0011);
        vt[17] = mk(1,1,0,1,0,0,2'b11,4'b0110);
        vt[18] = mk(0,0,0,1,0,0,2'b11,4'b0011);
        vt[19] = mk(0,0,1,0,0,0,2'b11,4'b1000);

        rst_n = 1'b0;
        drive(vt[0], 1'b0);
        repeat (2) @(negedge clk);
        check_all("reset state", 4'b0000, 1'b0, 2'b00);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i], 1'b1);
            @(negedge clk);
            m = model(vt[i]);
            check_all($sformatf("vec%0d", i), vt[i].exp, 1'b1, m[1:0]);
        end

        e = vt[19].exp; egp = model(vt[19]) & 6'b000011; ev = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 2'($urandom), 4'b0000);
            ev = $urandom_range(0, 3) != 0;
            drive(r, ev);
            if (ev) begin
                m = model(r);
                e = m[5:2];
                egp = m[1:0];
            end
            @(negedge clk);
            check_all($sformatf("rand%0d", i), e, ev, egp);
        end

        drive(vt[7], 1'b1);
        @(negedge clk);
        check_all("hold load", 4'b1101, 1'b1, 2'b11);
        drive(vt[14], 1'b0);
        @(negedge clk);
        check_all("hold 1", 4'b1101, 1'b0, 2'b11);
        drive(vt[16], 1'b0);
        @(negedge clk);
        check_all("hold 2", 4'b1101, 1'b0, 2'b11);

        drive(vt[9], 1'b1);
        @(negedge clk);
        check_all("pre reset load", 4'b1110, 1'b1, 2'b11);
        drive(vt[3], 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all("async reset", 4'b0000, 1'b0, 2'b00);
        @(negedge clk);
        check_all("reset discards capture", 4'b0000, 1'b0, 2'b00);
        drive(vt[9], 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("release idle", 4'b0000, 1'b0, 2'b00);
        drive(vt[9], 1'b1);
        @(negedge clk);
        check_all("first capture", 4'b1110, 1'b1, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
